// File: rtl/efpga_dot_seq.sv
// Dot-product sequencer: streams (a,b) beats through a registered-input,
// pipelined-product multiply-accumulate and returns the sum on a valid/ready port.
module efpga_dot_seq #(
  parameter int INPUT_WIDTH  = 18,
  parameter int OUTPUT_WIDTH = 40,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    len,
  output logic                    busy,
  input  logic [INPUT_WIDTH-1:0]  a,
  input  logic [INPUT_WIDTH-1:0]  b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] y,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    overflow
);

  localparam int PROD_W = 2 * INPUT_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Unsigned accumulate; the extra top bit is the carry-out used for the sticky overflow.
  function automatic logic [OUTPUT_WIDTH:0] acc_add(
    input logic [OUTPUT_WIDTH-1:0] acc,
    input logic [PROD_W-1:0]       p
  );
    acc_add = {1'b0, acc} + {{(OUTPUT_WIDTH + 1 - PROD_W){1'b0}}, p};
  endfunction

  logic [1:0]              state_q, state_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic [INPUT_WIDTH-1:0]  a_p0_q, a_p0_d;
  logic [INPUT_WIDTH-1:0]  b_p0_q, b_p0_d;
  logic                    vld_p0_q, vld_p0_d;
  logic [PROD_W-1:0]       prod_p1_q, prod_p1_d;
  logic                    vld_p1_q, vld_p1_d;
  logic [OUTPUT_WIDTH-1:0] y_q, y_d;
  logic                    ovf_q, ovf_d;
  logic [OUTPUT_WIDTH:0]   sum;
  logic                    accept;

  assign in_ready = (state_q == S_RUN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign y_valid  = (state_q == S_DONE);
  assign y        = y_q;
  assign overflow = ovf_q;
  assign sum      = acc_add(y_q, prod_p1_q);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = S_RUN;
            rem_d   = len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(LEN_WIDTH-1){1'b0}}, 1'b1}) state_d = S_DRAIN;
        end
      end
      // Only the last beat remains in flight here, so p1 valid with p0 empty is its accumulate.
      S_DRAIN: begin
        if (vld_p1_q && !vld_p0_q) state_d = S_DONE;
      end
      default: begin
        if (y_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    // Stage p0: register the accepted operands
    a_p0_d    = accept ? a : a_p0_q;
    b_p0_d    = accept ? b : b_p0_q;
    vld_p0_d  = accept;
    // Stage p1: full-width unsigned product
    prod_p1_d = vld_p0_q ? a_p0_q * b_p0_q : prod_p1_q;
    vld_p1_d  = vld_p0_q;
    // Stage p2: accumulate, wrapping modulo 2^OUTPUT_WIDTH
    y_d       = y_q;
    ovf_d     = ovf_q;
    if (vld_p1_q) begin
      y_d   = sum[OUTPUT_WIDTH-1:0];
      ovf_d = ovf_q | sum[OUTPUT_WIDTH];
    end
    if (state_q == S_IDLE && start) begin
      y_d   = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      a_p0_q    <= '0;
      b_p0_q    <= '0;
      vld_p0_q  <= 1'b0;
      prod_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      y_q       <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      a_p0_q    <= a_p0_d;
      b_p0_q    <= b_p0_d;
      vld_p0_q  <= vld_p0_d;
      prod_p1_q <= prod_p1_d;
      vld_p1_q  <= vld_p1_d;
      y_q       <= y_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_efpga_dot_seq.sv
// Bench for efpga_dot_seq: directed vectors; expected results queued at start,
// popped and compared by a monitor on every result handshake.
module tb_efpga_dot_seq;

  localparam int IW = 18;
  localparam int OW = 40;
  localparam int LW = 8;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic [IW-1:0] a;
  logic [IW-1:0] b;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] y;
  logic          y_valid;
  logic          y_ready;
  logic          overflow;

  efpga_dot_seq #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .len(len), .busy(busy),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .overflow(overflow)
  );

  typedef struct {
    logic [OW-1:0] y;
    logic          ovf;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: one comparison per result handshake
  always @(negedge clk) begin
    if (resetn && y_valid && y_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_y", y, e.y);
        chk("result_overflow", overflow, e.ovf);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LW-1:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
    len   = '0;
  endtask

  // Returns one step after the edge that accepted the beat; in_valid left high.
  task automatic send_beat(input logic [IW-1:0] av, input logic [IW-1:0] bv);
    int n;
    in_valid = 1'b1;
    a = av;
    b = bv;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    step();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!y_valid && n < 40) begin
      step();
      n++;
    end
    if (!y_valid) chk("y_valid_timeout", 0, 1);
    step();
    chk("busy_after_handshake", busy, 0);
  endtask

  function automatic exp_t mk(input logic [OW-1:0] yv, input logic ov);
    exp_t e;
    e.y = yv;
    e.ovf = ov;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] mx;
    mx       = '1;
    resetn   = 1'b0;
    start    = 1'b0;
    len      = '0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    y_ready  = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;
    step();

    // Back-to-back beats with latency check
    sbq.push_back(mk(40'd32, 1'b0));
    do_start(8'd3);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    send_beat(18'd1, 18'd4);
    send_beat(18'd2, 18'd5);
    send_beat(18'd3, 18'd6);
    in_valid = 1'b0;
    chk("t1_in_ready_after_last", in_ready, 0);
    chk("t1_y_valid_e0", y_valid, 0);
    step();
    chk("t1_y_valid_e1", y_valid, 0);
    step();
    chk("t1_y_valid_e2", y_valid, 1);
    step();
    chk("t1_y_valid_after_hs", y_valid, 0);
    chk("t1_busy_after_hs", busy, 0);

    // Bubbles between beats must not advance the count
    sbq.push_back(mk(40'd32, 1'b0));
    do_start(8'd3);
    send_beat(18'd1, 18'd4);
    in_valid = 1'b0;
    repeat (2) step();
    send_beat(18'd2, 18'd5);
    in_valid = 1'b0;
    repeat (2) step();
    chk("t2_in_ready_in_bubble", in_ready, 1);
    send_beat(18'd3, 18'd6);
    in_valid = 1'b0;
    chk("t2_in_ready_after_last", in_ready, 0);
    wait_done();

    // Zero length, consumer stalled, start ignored while in DONE
    y_ready = 1'b0;
    sbq.push_back(mk(40'd0, 1'b0));
    do_start(8'd0);
    chk("t3_y_valid", y_valid, 1);
    chk("t3_in_ready", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        start = 1'b1;
        len   = 8'd5;
      end
      step();
      start = 1'b0;
      len   = '0;
      chk("t3_hold_y_valid", y_valid, 1);
      chk("t3_hold_busy", busy, 1);
      chk("t3_hold_y", y, 0);
      chk("t3_hold_in_ready", in_ready, 0);
    end
    y_ready = 1'b1;
    step();
    chk("t3_y_valid_after_hs", y_valid, 0);
    chk("t3_busy_after_hs", busy, 0);

    // Accumulator wrap and sticky overflow
    sbq.push_back(mk(40'd1099503239184, 1'b0));
    do_start(8'd16);
    for (int i = 0; i < 16; i++) send_beat(mx, mx);
    in_valid = 1'b0;
    wait_done();
    sbq.push_back(mk(40'd68710563857, 1'b1));
    do_start(8'd17);
    for (int i = 0; i < 17; i++) send_beat(mx, mx);
    in_valid = 1'b0;
    wait_done();
    chk("t4_overflow_held_idle", overflow, 1);
    sbq.push_back(mk(40'd6, 1'b0));
    do_start(8'd1);
    chk("t4_overflow_cleared", overflow, 0);
    send_beat(18'd2, 18'd3);
    in_valid = 1'b0;
    wait_done();

    // Reset mid-run aborts with no result
    do_start(8'd5);
    send_beat(18'd100, 18'd100);
    send_beat(18'd200, 18'd200);
    a = 18'd300;
    b = 18'd300;
    resetn = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    chk("t5_rst_y", y, 0);
    chk("t5_rst_y_valid", y_valid, 0);
    chk("t5_rst_overflow", overflow, 0);
    in_valid = 1'b0;
    repeat (3) step();
    chk("t5_rst_y_valid_held", y_valid, 0);
    resetn = 1'b1;
    step();
    sbq.push_back(mk(40'd50, 1'b0));
    do_start(8'd2);
    send_beat(18'd7, 18'd7);
    send_beat(18'd1, 18'd1);
    in_valid = 1'b0;
    wait_done();

    repeat (5) step();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/efpga_dot_seq.md
Name: efpga_dot_seq

Overview:
- Sequencer that runs one pipelined multiply-accumulate datapath to compute a dot product of a streamed vector of operand pairs.
- Software or a host FSM issues start with a length. The block accepts operand beats over a valid/ready handshake and drives the registered-input, pipelined-product accumulate pipeline. It presents the final sum on a valid/ready result port.
- Sits between an operand-streaming front end (FIFO/DMA) and the eFPGA arithmetic macros.

Parameters:
- INPUT_WIDTH, 18, width of each unsigned operand a and b.
- OUTPUT_WIDTH, 40, accumulator and result width; must be >= 2*INPUT_WIDTH.
- LEN_WIDTH, 8, width of the vector length field; max vector length 2^LEN_WIDTH-1.

Ports:
- clk  input  1  clock; all state on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a new dot product; honoured only in IDLE.
- len  input  LEN_WIDTH  number of operand pairs; sampled with start.
- busy  output  1  high in every state except IDLE.
- a  input  INPUT_WIDTH  operand A of the current beat.
- b  input  INPUT_WIDTH  operand B of the current beat.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat; high only in RUN.
- y  output  OUTPUT_WIDTH  accumulated result.
- y_valid  output  1  result valid; high only in DONE.
- y_ready  input  1  result consumer ready.
- overflow  output  1  sticky: accumulator carry-out occurred during the current operation.

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, in_ready=0, y=0, y_valid=0, overflow=0. All pipeline registers, valid bits and the beat counter are 0.
- Reset asserted mid-operation aborts immediately: the in-flight pipeline contents are discarded and no y_valid is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN: start=1 with len!=0. Same edge: accumulator y<=0, overflow<=0, remaining<=len.
- IDLE -> DONE: start=1 with len==0. Same edge: y<=0, overflow<=0. y_valid is high the next cycle.
- start in any state other than IDLE is ignored, with no side effects.
- RUN:
  - in_ready=1 combinationally from the state.
  - A beat is accepted on any edge where in_valid&in_ready.
  - Bubbles (in_valid=0) are allowed indefinitely and do not advance the counter.
  - Each accepted beat decrements remaining.
  - The edge accepting the beat with remaining==1 moves the FSM to DRAIN; in_ready is 0 from the following cycle.
- Datapath pipeline, per accepted beat at edge E0:
  - E0: a_reg<=a, b_reg<=b, v1<=1.
  - E1: prod<=a_reg*b_reg (2*INPUT_WIDTH bits, unsigned), v2<=v1.
  - E2: y<=y+zero_extend(prod) when v2.
- Back-to-back beats fully pipeline, one per cycle.
- DRAIN: wait until v1=0 and v2=0 with the final accumulate complete. The transition to DONE occurs on the same edge as the last accumulate (E2 of the last beat).
- Latency: y_valid=1 in the cycle after E2 of the last beat, i.e. 3 edges after last-beat acceptance, counting the accept edge.
- DONE:
  - y_valid=1; y and overflow are held stable.
  - On an edge with y_ready=1 -> IDLE, and y_valid drops the next cycle.
  - y_ready=0 holds DONE indefinitely.
  - y and overflow keep their values in IDLE until the next start.
- Arithmetic: unsigned; the sum wraps modulo 2^OUTPUT_WIDTH. overflow sets on any accumulate with carry-out of bit OUTPUT_WIDTH-1 and stays set until the next start.
- busy=1 in RUN, DRAIN and DONE.

Test Plan:
- len=3; beats (a,b)=(1,4),(2,5),(3,6) back-to-back, y_ready=1 -> y_valid one cycle; y=32; overflow=0; y_valid asserted exactly 3 edges after the third beat is accepted; busy low the cycle after handshake.
- len=3, same beats with in_valid deasserted 2 cycles between each beat -> y=32; in_ready low after the third beat; counter is not decremented on bubbles.
- len=0 with start -> DONE next cycle with y=0, y_valid=1; in_ready never asserted. Also: hold y_ready=0 for 10 cycles -> y_valid, y and busy stable; a start pulse during this window is ignored.
- Overflow with 2^18-1 on both operands: len=16 -> y=1099503239184, overflow=0. len=17 -> y=68710563857, overflow=1. A following start with len=1 and (2,3) -> y=6, overflow=0.
- Reset mid-run: len=5, assert resetn=0 after 2 beats are accepted, release, then start len=2 with (7,7),(1,1) -> all outputs 0 during reset; result y=50, with no stale contribution.
